// File: rtl/quad_mouse_decoder.sv
// Turns two quadrature axes and one button into a PS/2-style movement packet.
// Each axis keeps a saturating accumulator. The report divider sets how often
// a packet can go out; each new packet updates every field and flips bit 24.
module quad_mouse_decoder #(
    parameter int DIV_BITS = 12,
    parameter int SAT      = 511
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        x1,
    input  logic        x2,
    input  logic        y1,
    input  logic        y2,
    input  logic        button,
    output logic [24:0] ps2_mouse
);

    localparam logic signed [10:0] SAT_P = 11'(SAT);

    // Synchronizer bit order: {button, y2, y1, x2, x1}
    logic [4:0] sync_a, sync_b;
    logic       x1s, x2s, y1s, y2s, btns;
    logic       x1_prev, y1_prev;
    logic signed [9:0] acc_x, acc_y;
    logic [DIV_BITS-1:0] div_cnt;
    logic       last_btn;

    logic       tick, emit;
    logic       step_x, step_y, up_x, up_y;
    logic [9:0] clamp_x, clamp_y;
    logic signed [9:0] acc_x_nxt, acc_y_nxt;

    assign x1s  = sync_b[0];
    assign x2s  = sync_b[1];
    assign y1s  = sync_b[2];
    assign y2s  = sync_b[3];
    assign btns = sync_b[4];

    // Returns {overflow, 9-bit reported move}.
    function automatic logic [9:0] clamp_move(input logic signed [9:0] acc);
        if (acc > 10'sd255)
            return {1'b1, 9'h0FF};
        if (acc < -10'sd256)
            return {1'b1, 9'h100};
        return {1'b0, acc[8:0]};
    endfunction

    // Remove the reported part first, then add this cycle's step.
    // The limit is checked against that combined result, so a step that
    // lands in the same cycle as a report is counted exactly once.
    function automatic logic signed [9:0] acc_next(
        input logic signed [9:0] acc,
        input logic [8:0]        rep,
        input logic              do_emit,
        input logic              stp,
        input logic              up
    );
        logic signed [10:0] base;
        logic signed [10:0] sum;
        base = {acc[9], acc};
        if (do_emit)
            base = base - $signed({{2{rep[8]}}, rep});
        sum = base;
        if (stp)
            sum = up ? base + 11'sd1 : base - 11'sd1;
        if (sum > SAT_P || sum < -SAT_P)
            sum = base;
        return sum[9:0];
    endfunction

    always_comb begin
        step_x    = x1s != x1_prev;
        step_y    = y1s != y1_prev;
        up_x      = x2s != x1s;
        up_y      = y2s != y1s;
        tick      = ce && (div_cnt == '0);
        emit      = tick && ((acc_x != 10'sd0) || (acc_y != 10'sd0) || (btns != last_btn));
        clamp_x   = clamp_move(acc_x);
        clamp_y   = clamp_move(acc_y);
        acc_x_nxt = acc_next(acc_x, clamp_x[8:0], emit, step_x, up_x);
        acc_y_nxt = acc_next(acc_y, clamp_y[8:0], emit, step_y, up_y);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a    <= 5'b10000;
            sync_b    <= 5'b10000;
            x1_prev   <= 1'b0;
            y1_prev   <= 1'b0;
            acc_x     <= '0;
            acc_y     <= '0;
            div_cnt   <= '0;
            last_btn  <= 1'b1;
            ps2_mouse <= 25'h0000008;
        end else begin
            sync_a  <= {button, y2, y1, x2, x1};
            sync_b  <= sync_a;
            x1_prev <= x1s;
            y1_prev <= y1s;
            acc_x   <= acc_x_nxt;
            acc_y   <= acc_y_nxt;
            if (ce)
                div_cnt <= div_cnt + DIV_BITS'(1);
            if (emit) begin
                last_btn  <= btns;
                ps2_mouse <= {~ps2_mouse[24], clamp_y[7:0], clamp_x[7:0],
                              clamp_y[9], clamp_x[9], clamp_y[8], clamp_x[8],
                              1'b1, 2'b00, ~btns};
            end
        end
    end

endmodule

// File: tb/tb_quad_mouse_decoder.sv
// Scoreboard bench for quad_mouse_decoder, built with a small divider.
// Expected packets are queued when ticks are driven and compared when bit 24 toggles.
module tb_quad_mouse_decoder;

    logic        clk = 1'b0;
    logic        reset, ce, x1, x2, y1, y2, button;
    logic [24:0] ps2_mouse;

    always #5 clk = ~clk;

    quad_mouse_decoder #(.DIV_BITS(2), .SAT(511)) dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .x1        (x1),
        .x2        (x2),
        .y1        (y1),
        .y2        (y2),
        .button    (button),
        .ps2_mouse (ps2_mouse)
    );

    int          n_vec = 0;
    int          n_mis = 0;
    logic [24:0] exp_q[$];
    int          ax = 0, ay = 0;
    logic        btn_m = 1'b1, last_m = 1'b1, strb_m = 1'b0;
    logic        prev_strb = 1'b0;

    task automatic chk(input string tag, input logic [24:0] obs, input logic [24:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL %s: got %h want %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [9:0] clampv(input int a);
        if (a > 255)  return {1'b1, 9'h0FF};
        if (a < -256) return {1'b1, 9'h100};
        return {1'b0, 9'(a)};
    endfunction

    function automatic int sat_add(input int a, input bit up);
        int s;
        s = up ? a + 1 : a - 1;
        return (s > 511 || s < -511) ? a : s;
    endfunction

    // Predicts one emitted packet from the model state and queues it.
    task automatic do_emit();
        logic [9:0] cx, cy;
        cx = clampv(ax);
        cy = clampv(ay);
        strb_m = ~strb_m;
        exp_q.push_back({strb_m, cy[7:0], cx[7:0], cy[9], cx[9], cy[8], cx[8],
                         1'b1, 2'b00, ~btn_m});
        ax = ax - int'($signed(cx[8:0]));
        ay = ay - int'($signed(cy[8:0]));
        last_m = btn_m;
    endtask

    // Walks the 2-bit divider from 1 back to 0 without a tick.
    task automatic rest_pulses();
        repeat (3) begin
            @(negedge clk); ce = 1'b1;
            @(negedge clk); ce = 1'b0;
        end
    endtask

    task automatic step(input bit is_y, input bit up);
        if (!is_y) begin
            x1 = ~x1; x2 = up ? ~x1 : x1;
            ax = sat_add(ax, up);
        end else begin
            y1 = ~y1; y2 = up ? ~y1 : y1;
            ay = sat_add(ay, up);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic set_button(input logic b);
        button = b;
        btn_m  = b;
        repeat (4) @(negedge clk);
    endtask

    task automatic tick(input string tag);
        bit emitting;
        repeat (4) @(negedge clk);
        emitting = (ax != 0) || (ay != 0) || (btn_m != last_m);
        if (emitting) do_emit();
        ce = 1'b1;
        @(negedge clk); ce = 1'b0;
        rest_pulses();
        repeat (2) @(negedge clk);
        if (emitting)
            chk({tag, "_drained"}, 25'(exp_q.size()), 25'd0);
        else
            chk({tag, "_no_pkt"}, 25'(ps2_mouse[24]), 25'(strb_m));
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_strb = ps2_mouse[24];
        end else if (ps2_mouse[24] !== prev_strb) begin
            prev_strb = ps2_mouse[24];
            chk("pkt_expected", 25'(exp_q.size() != 0), 25'd1);
            if (exp_q.size() != 0)
                chk("pkt", ps2_mouse, exp_q.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; ce = 1'b0; button = 1'b1;
        x1 = 1'b0; x2 = 1'b0; y1 = 1'b0; y2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_val", ps2_mouse, 25'h0000008);
        reset = 1'b0;

        // Three +X steps, then a tick that must leave no residue.
        repeat (3) step(0, 1);
        tick("x_plus3");
        tick("x_acc_zero");
        // Toggling x2 alone must not count as a step.
        x2 = ~x2;
        tick("x2_only");

        repeat (5) step(1, 0);
        tick("y_minus5");

        repeat (300) step(0, 1);
        tick("x300_a");
        tick("x300_b");

        // Drive 520 steps into the X accumulator; it must hold at +511 without wrapping.
        repeat (520) step(0, 1);
        tick("sat_a");
        tick("sat_b");
        tick("sat_c");
        tick("sat_idle");

        set_button(1'b0);
        tick("btn_press");
        tick("btn_hold");
        set_button(1'b1);
        tick("btn_release");

        repeat (2) step(0, 0);
        repeat (3) step(1, 1);
        tick("mixed");

        // The step is decoded in the same cycle as the emission.
        repeat (2) step(1, 1);
        repeat (4) @(negedge clk);
        x1 = ~x1; x2 = ~x1;
        repeat (2) @(negedge clk);
        do_emit();
        ce = 1'b1;
        @(negedge clk); ce = 1'b0;
        ax = sat_add(ax, 1);
        rest_pulses();
        repeat (2) @(negedge clk);
        chk("coinc_drained", 25'(exp_q.size()), 25'd0);
        tick("coinc_follow");

        // Reset in the middle of accumulation; park x1/y1 low so reset leaves no edge behind.
        repeat (2) step(0, 1);
        if (x1) step(0, 1);
        if (y1) step(1, 1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_mid", ps2_mouse, 25'h0000008);
        reset = 1'b0;
        ax = 0; ay = 0; strb_m = 1'b0; last_m = 1'b1;
        tick("post_reset_none");
        step(0, 1);
        tick("post_reset_pkt");

        repeat (4) @(negedge clk);
        chk("final_queue", 25'(exp_q.size()), 25'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
